// File: rtl/cello_tt_pkg.sv
// Shared types and constants for the 3-input truth-table sweeper.
package cello_tt_pkg;
    localparam int ROWS  = 8;
    localparam int ROW_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } tt_state_e;

    // Row 000 lands in the MSB of the captured table, row 111 in the LSB.
    function automatic logic [ROW_W-1:0] tt_bit(input logic [ROW_W-1:0] row);
        return ROW_W'(ROWS - 1) - row;
    endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: counts cycles a row has been held; tc_o marks the sample cycle.
module tt_settle_timer
    import cello_tt_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/truth_table_sweep.sv
// Drives all 8 input rows of a 3-input stage, captures its output per row,
// and compares the captured truth table against an expected one.
module truth_table_sweep
    import cello_tt_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_tt,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       match
);
    tt_state_e        state_q;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] drv_q;
    logic [7:0]       exp_q;
    logic [7:0]       tt_q;
    logic [7:0]       tt_d;
    logic             match_q;
    logic             busy_q;
    logic             done_q;
    logic             tc;
    logic             tmr_load;
    logic             tmr_en;

    // Timer restarts on sweep entry, after every sample, and on abort.
    assign tmr_load = ((state_q == IDLE) && start) ||
                      ((state_q == SWEEP) && (tc || abort));
    assign tmr_en   = (state_q == SWEEP);

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tc)
    );

    always_comb begin
        tt_d = tt_q;
        tt_d[tt_bit(row_q)] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            drv_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q   <= exp_tt;
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        row_q   <= '0;
                        drv_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        row_q   <= '0;
                        drv_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tc) begin
                        tt_q <= tt_d;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            // Compare against the table including this last bit so match lines up with done.
                            match_q <= (tt_d == exp_q);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            drv_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            row_q <= row_q + 3'd1;
                            drv_q <= row_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    row_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {in1, in2, in3} = drv_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tt    = tt_q;
    assign match = match_q;
endmodule

// File: tb/tb_truth_table_sweep.sv
// Runs a SETTLE=4 and a SETTLE=1 sweeper side by side against behavioural stages.
module tb_truth_table_sweep;
    localparam int S0 = 4;
    localparam int S1 = 1;
    localparam int NONE = 1000;
    localparam int LAST_K = 36;

    logic       clk = 1'b0;
    logic       rst;
    logic       start   [2];
    logic       abort   [2];
    logic [7:0] exp_tt  [2];
    logic       dut_out [2];
    logic       in1 [2], in2 [2], in3 [2];
    logic       busy [2], done [2], match [2];
    logic [7:0] tt [2];
    logic [7:0] stage [2];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Behavioural 3-input stage: its truth table, MSB = row 000.
    assign dut_out[0] = stage[0][3'd7 - {in1[0], in2[0], in3[0]}];
    assign dut_out[1] = stage[1][3'd7 - {in1[1], in2[1], in3[1]}];

    truth_table_sweep #(.SETTLE(S0)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .exp_tt(exp_tt[0]),
        .dut_out(dut_out[0]), .in1(in1[0]), .in2(in2[0]), .in3(in3[0]),
        .busy(busy[0]), .done(done[0]), .tt(tt[0]), .match(match[0])
    );

    truth_table_sweep #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .exp_tt(exp_tt[1]),
        .dut_out(dut_out[1]), .in1(in1[1]), .in2(in2[1]), .in3(in3[1]),
        .busy(busy[1]), .done(done[1]), .tt(tt[1]), .match(match[1])
    );

    function automatic int settle(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at cycle k after start (cycle 0), with the run cut off after cycle e.
    task automatic check_cycle(input int i, input int k, input int e,
                               input logic [7:0] st, input logic [7:0] ex);
        int s;
        int n;
        logic [7:0] mask;
        logic [31:0] eb, ed, ein, ett, em;
        s = settle(i);
        if (k > e) begin
            eb = 0; ed = 0; ein = 0; ett = 0; em = 0;
        end else begin
            eb  = (k >= 1 && k <= 8 * s) ? 1 : 0;
            ed  = (k == 8 * s + 1) ? 1 : 0;
            ein = (k <= 8 * s) ? (k - 1) / s : 0;
            n   = (k - 1) / s;
            if (n > 8) n = 8;
            mask = (n == 0) ? 8'h00 : 8'(8'hFF << (8 - n));
            ett = st & mask;
            em  = (k > 8 * s) ? ((st == ex) ? 1 : 0) : 0;
        end
        chk($sformatf("d%0d k%0d busy", i, k), busy[i], eb);
        chk($sformatf("d%0d k%0d done", i, k), done[i], ed);
        chk($sformatf("d%0d k%0d in", i, k), {in1[i], in2[i], in3[i]}, ein);
        chk($sformatf("d%0d k%0d tt", i, k), tt[i], ett);
        chk($sformatf("d%0d k%0d match", i, k), match[i], em);
    endtask

    // Both DUTs start at cycle 0; restart/abort/sa0 disturb only the SETTLE=4 one, rst hits both.
    task automatic do_sweep(input logic [7:0] st0, input logic [7:0] ex0,
                            input logic [7:0] st1, input logic [7:0] ex1,
                            input int restart_k, input int abort_k, input int rst_k,
                            input bit sa0);
        int e0;
        int e1;
        e0 = (abort_k < rst_k) ? abort_k : rst_k;
        e1 = rst_k;
        stage[0] = st0;
        stage[1] = st1;
        for (int k = 0; k <= LAST_K; k++) begin
            if (k >= 1) begin
                check_cycle(0, k, e0, st0, ex0);
                check_cycle(1, k, e1, st1, ex1);
            end
            // exp_tt is scrambled after cycle 0 to show only the start-cycle value counts.
            exp_tt[0] = (k == 0) ? ex0 : ~ex0;
            exp_tt[1] = (k == 0) ? ex1 : ~ex1;
            start[0]  = (k == 0) || (k == restart_k);
            start[1]  = (k == 0);
            abort[0]  = (k == abort_k) || (sa0 && k == 0);
            abort[1]  = 1'b0;
            rst       = (k == rst_k);
            tick();
        end
        start[0] = 1'b0; start[1] = 1'b0;
        abort[0] = 1'b0; abort[1] = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r0, r1, x0, x1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; exp_tt[i] = 8'h00; stage[i] = 8'h00;
        end
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst d%0d busy", i), busy[i], 0);
            chk($sformatf("rst d%0d done", i), done[i], 0);
            chk($sformatf("rst d%0d in", i), {in1[i], in2[i], in3[i]}, 0);
            chk($sformatf("rst d%0d tt", i), tt[i], 0);
            chk($sformatf("rst d%0d match", i), match[i], 0);
        end
        rst = 1'b0;
        tick();

        do_sweep(8'h09, 8'h09, 8'h00, 8'h00, -1, NONE, NONE, 1'b0);
        do_sweep(8'h09, 8'h08, 8'h09, 8'h09, 10, NONE, NONE, 1'b0);
        do_sweep(8'hFF, 8'hFF, 8'h00, 8'h01, -1, NONE, NONE, 1'b0);
        do_sweep(8'h5A, 8'h5A, 8'h33, 8'h33, -1, 14, NONE, 1'b0);
        do_sweep(8'hC3, 8'hC3, 8'h96, 8'h96, -1, NONE, 22, 1'b0);
        do_sweep(8'h6E, 8'h6E, 8'h81, 8'h80, -1, NONE, NONE, 1'b1);

        for (int t = 0; t < 6; t++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            x0 = ($urandom_range(0, 1) == 1) ? r0 : 8'($urandom);
            x1 = ($urandom_range(0, 1) == 1) ? r1 : 8'($urandom);
            do_sweep(r0, x0, r1, x1, (t % 2 == 0) ? int'($urandom_range(2, 30)) : -1,
                     NONE, NONE, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of clock cycles each input row is held before the output is sampled (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for the whole block.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a sweep.
REQ-005 SHALL have port abort  input  1  cancels a sweep in progress.
REQ-006 SHALL have port exp_tt  input  8  expected truth table, sampled at start acceptance.
REQ-007 SHALL have port dut_out  input  1  output of the 3-input logic stage under sweep.
REQ-008 SHALL have ports in1, in2, in3  output  1 each  drive the 3-input stage; in1 is the MSB.
REQ-009 SHALL have port busy  output  1  high while a sweep is running.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 SHALL have port tt  output  8  captured truth table.
REQ-012 SHALL have port match  output  1  tt equals the latched exp_tt.

Function
REQ-013 SHALL implement the FSM states IDLE, SWEEP and DONE.
REQ-014 SHALL, in IDLE with start=1, latch exp_tt, clear tt to 0x00, set row=0 and cnt=0, and enter SWEEP on the next edge.
REQ-015 SHALL, in SWEEP, drive {in1,in2,in3}=row; in IDLE and DONE it SHALL drive 000.
REQ-016 SHALL, in SWEEP, increment cnt each cycle; when cnt==SETTLE-1 it SHALL write dut_out into tt bit (7-row) on that edge.
REQ-017 Bit mapping is fixed: tt[7] is row 000 and tt[0] is row 111, so a stage with true rows 100 and 111 yields 0x09.
REQ-018 SHALL, on the sample edge, set row=row+1 and cnt=0 if row<7; if row==7 it SHALL enter DONE.
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle, register match=(tt==latched exp_tt), then return to IDLE.
REQ-020 Timing: with start accepted at cycle t, done SHALL be high at cycle t+8*SETTLE+1; busy SHALL be high from t+1 through t+8*SETTLE inclusive.
REQ-021 SHALL ignore start while in SWEEP or DONE; no queuing.
REQ-022 SHALL, on abort=1 in SWEEP, go to IDLE on the next edge, clear tt and match, and not pulse done.
REQ-023 abort SHALL be ignored in IDLE and DONE; if abort and start are both high in IDLE, start wins.
REQ-024 tt and match SHALL hold their values in IDLE until the next accepted start or abort.
REQ-025 row SHALL be 3 bits and never wrap in operation; cnt SHALL be 8 bits and compare against SETTLE-1.
REQ-026 dut_out SHALL be assumed synchronous to clk; no synchronizer is included.

Reset
REQ-027 rst=1 SHALL force IDLE, row=0, cnt=0, tt=0x00, latched exp_tt=0x00, match=0, done=0, busy=0, in1..in3=0 on the next edge.
REQ-028 rst SHALL take priority over start and abort, including a reset asserted mid-sweep.

Structure
REQ-029 SHALL place the state enum (IDLE/SWEEP/DONE), ROWS=8 and ROW_W=3 in shared package cello_tt_pkg.
REQ-030 SHALL implement the settle timer as sub-module tt_settle_timer (load, enable, terminal-count output); everything else stays in one FSM.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 SETTLE=4, dut_out driven by a behavioural model of the 3-input stage with true rows 100 and 111, exp_tt=0x09, start at cycle 0 -> done at cycle 33, tt=0x09, match=1.
REQ-033 Same stage model, exp_tt=0x08 -> tt=0x09, match=0; dut_out tied to 1 -> tt=0xFF.
REQ-034 SETTLE=1, dut_out tied to 0, start at cycle 0 -> in1..in3 step 000..111 over cycles 1..8, done at cycle 9, tt=0x00.
REQ-035 start pulsed again at cycle 10 of a SETTLE=4 sweep -> ignored; done pulses only once, at cycle 33.
REQ-036 abort at row 3 -> IDLE next cycle, tt=0x00, no done pulse; rst at row 5 -> all outputs 0 next cycle; start and abort together in IDLE -> sweep begins.
